// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, prefix bytes and ps2_key field positions
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DECODE} ps2_state_t;
    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
    localparam int KEY_TOGGLE = 10;
    localparam int KEY_PRESSED = 9;
    localparam int KEY_EXT = 8;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser plus debounce; the output follows only after FILTER_LEN equal samples
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic line
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b11;
            cnt  <= '0;
            line <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == line) cnt <= '0;
            else if (cnt == CW'(FILTER_LEN - 1)) begin
                line <= sync[1];
                cnt  <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ps2_key_deserializer.sv
// ps2_key_deserializer: PS/2 device stream to ps2_key events; define PS2_PARITY_CHECK_EN to drop bad-parity frames
module ps2_key_deserializer
    import ps2_pkg::*;
#(
    parameter int CLK_HZ = 24000000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        frame_err
);
    localparam int TMAX = CLK_HZ / 1_000_000 * TIMEOUT_US - 1;
    localparam int TW = $clog2(TMAX + 1);
    ps2_state_t state, state_n;
    logic clk_f, data_f, clk_d, fe, tmo, err, valid, in_frame, ext, brk;
    logic [2:0] bitcnt;
    logic [7:0] sreg;
    logic [TW-1:0] tcnt;
`ifdef PS2_PARITY_CHECK_EN
    logic par;
`endif

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (.clk, .reset_n, .raw(ps2_clk_in), .line(clk_f));
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (.clk, .reset_n, .raw(ps2_data_in), .line(data_f));

    assign fe = clk_d & ~clk_f;
    assign in_frame = state inside {DATA, PARITY, STOP};
    // a falling edge landing on the terminal count keeps the frame alive
    assign tmo = !fe && tcnt == TW'(TMAX);
`ifdef PS2_PARITY_CHECK_EN
    assign valid = data_f && (^{sreg, par});
`else
    assign valid = data_f;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        err = 1'b0;
        case (state)
            IDLE: begin
                state_n = fe && !data_f ? DATA : IDLE;
                err = fe && data_f;
            end
            DATA:   state_n = fe && bitcnt == 3'd7 ? PARITY : DATA;
            PARITY: state_n = fe ? STOP : PARITY;
            STOP: begin
                state_n = fe ? (valid ? DECODE : IDLE) : STOP;
                err = fe && !valid;
            end
            default: state_n = IDLE;
        endcase
        if (in_frame && tmo) begin
            state_n = IDLE;
            err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_d     <= 1'b1;
            bitcnt    <= '0;
            sreg      <= '0;
            tcnt      <= '0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            ps2_key   <= '0;
            frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par       <= 1'b0;
`endif
        end else begin
            clk_d     <= clk_f;
            frame_err <= err;
            tcnt      <= in_frame && !fe && !tmo ? tcnt + 1'b1 : '0;
            if (state == IDLE) bitcnt <= '0;
            else if (fe && state == DATA) begin
                sreg   <= {data_f, sreg[7:1]};
                bitcnt <= bitcnt + 1'b1;
            end
`ifdef PS2_PARITY_CHECK_EN
            if (fe && state == PARITY) par <= data_f;
`endif
            if (state == DECODE) begin
                if (sreg == PS2_PREFIX_EXT) ext <= 1'b1;
                else if (sreg == PS2_PREFIX_BREAK) brk <= 1'b1;
                else begin
                    ps2_key[KEY_TOGGLE]  <= ~ps2_key[KEY_TOGGLE];
                    ps2_key[KEY_PRESSED] <= ~brk;
                    ps2_key[KEY_EXT]     <= ext;
                    ps2_key[7:0]         <= sreg;
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
            if (err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end
endmodule
